// File: rtl/obstacle_scroller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_scroller_pkg                                              |
// | Shared game constants: phase encoding and playfield defaults.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package obstacle_scroller_pkg;
   localparam int H_RES          = 1920;
   localparam int X_START        = 1920;
   localparam int STEP_INIT      = 4;
   localparam int STEP_MAX       = 32;
   localparam int TICKS_PER_STEP = 1000;
   localparam int TS_W           = 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HIT  = 2'd2;
endpackage
`default_nettype wire

// File: rtl/obstacle_scroller_step_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | step_timer                                                         |
// | Counts accepted moves into time steps and ramps speed, saturating. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module step_timer #(
   parameter int STEP_INIT      = 4,
   parameter int STEP_MAX       = 32,
   parameter int TICKS_PER_STEP = 1000,
   parameter int TS_W           = 8,
   parameter int SPD_W          = $clog2(STEP_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             tick_en,
   output logic [SPD_W-1:0] speed,
   output logic [TS_W-1:0]  time_step
);
   localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICKS_PER_STEP - 1);
   localparam logic [SPD_W-1:0] c_SPD_INIT  = SPD_W'(STEP_INIT);
   localparam logic [SPD_W-1:0] c_SPD_MAX   = SPD_W'(STEP_MAX);

   logic [CNT_W-1:0] r_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick    <= '0;
         speed     <= c_SPD_INIT;
         time_step <= '0;
      end else if (clear) begin
         r_tick    <= '0;
         speed     <= c_SPD_INIT;
         time_step <= '0;
      end else if (tick_en) begin
         if (r_tick == c_TICK_LAST) begin
            r_tick <= '0;
            if (time_step != '1)
               time_step <= time_step + 1'b1;
            if (speed < c_SPD_MAX)
               speed <= speed + 1'b1;
         end else begin
            r_tick <= r_tick + 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/obstacle_scroller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | obstacle_scroller                                                  |
// | Game-phase FSM plus obstacle position/wrap datapath driven by mv.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module obstacle_scroller #(
   parameter int X_START        = obstacle_scroller_pkg::X_START,
   parameter int STEP_INIT      = obstacle_scroller_pkg::STEP_INIT,
   parameter int STEP_MAX       = obstacle_scroller_pkg::STEP_MAX,
   parameter int TICKS_PER_STEP = obstacle_scroller_pkg::TICKS_PER_STEP,
   parameter int TS_W           = obstacle_scroller_pkg::TS_W,
   parameter int X_W            = $clog2(X_START + 1),
   parameter int SPD_W          = $clog2(STEP_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mv,
   input  logic             run,
   input  logic             collide,
   output logic [X_W-1:0]   obj_x,
   output logic             obj_valid,
   output logic [SPD_W-1:0] speed,
   output logic [TS_W-1:0]  time_step,
   output logic             wrap,
   output logic [1:0]       state
);
   import obstacle_scroller_pkg::*;

   localparam logic [X_W-1:0] c_X_START = X_W'(X_START);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       w_accept;
   logic       w_clear;
   logic       w_under;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // collide outranks run-drop in RUN; HIT only leaves when run falls
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (run) w_state_nxt = RUN;
         RUN: begin
            if (collide)   w_state_nxt = HIT;
            else if (!run) w_state_nxt = IDLE;
         end
         HIT:     if (!run) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_accept = (r_state == RUN) && !collide && run && mv;
      w_clear  = (w_state_nxt == IDLE);
      w_under  = (obj_x < X_W'(speed));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         obj_x     <= c_X_START;
         obj_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         obj_valid <= (w_state_nxt == RUN) || (w_state_nxt == HIT);
         wrap      <= w_accept && w_under;
         if (w_clear)
            obj_x <= c_X_START;
         else if (w_accept)
            obj_x <= w_under ? c_X_START : obj_x - X_W'(speed);
      end
   end

   assign state = r_state;

   // speed seen here is the pre-increment value, so a ramping mv moves by the old step
   step_timer #(
      .STEP_INIT      (STEP_INIT),
      .STEP_MAX       (STEP_MAX),
      .TICKS_PER_STEP (TICKS_PER_STEP),
      .TS_W           (TS_W),
      .SPD_W          (SPD_W)
   ) u_step_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (w_clear),
      .tick_en   (w_accept),
      .speed     (speed),
      .time_step (time_step)
   );
endmodule
`default_nettype wire

// File: tb/tb_obstacle_scroller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_obstacle_scroller                                               |
// | Directed bench with a reference model and expected-value queue.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_obstacle_scroller;
   logic        clk = 1'b0;
   logic        rst, mv, run, collide;
   logic [10:0] obj_x;
   logic        obj_valid;
   logic [5:0]  speed;
   logic [7:0]  time_step;
   logic        wrap;
   logic [1:0]  state;

   always #5 clk = ~clk;

   obstacle_scroller dut (
      .clk       (clk),
      .rst       (rst),
      .mv        (mv),
      .run       (run),
      .collide   (collide),
      .obj_x     (obj_x),
      .obj_valid (obj_valid),
      .speed     (speed),
      .time_step (time_step),
      .wrap      (wrap),
      .state     (state)
   );

   int checks = 0;
   int errors = 0;
   int m_x, m_spd, m_ts, m_tick, m_total;

   typedef struct {
      int x;
      int w;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_x = 1920; m_spd = 4; m_ts = 0; m_tick = 0; m_total = 0;
   endtask

   task automatic model_mv(output int w);
      w = 0;
      if (m_x < m_spd) begin
         m_x = 1920;
         w   = 1;
      end else begin
         m_x = m_x - m_spd;
      end
      m_total++;
      if (m_tick == 999) begin
         m_tick = 0;
         if (m_ts < 255) m_ts++;
         if (m_spd < 32) m_spd++;
      end else begin
         m_tick++;
      end
   endtask

   task automatic single_mv(input string tag);
      exp_t e;
      int   w;
      model_mv(w);
      e.x = m_x;
      e.w = w;
      sb.push_back(e);
      mv = 1'b1;
      tick();
      mv = 1'b0;
      e = sb.pop_front();
      check({tag, "_x"}, 32'(obj_x), e.x);
      check({tag, "_wrap"}, 32'(wrap), e.w);
   endtask

   task automatic bulk_mv(input int n);
      int w;
      mv = 1'b1;
      for (int i = 0; i < n; i++) begin
         model_mv(w);
         tick();
      end
      mv = 1'b0;
   endtask

   task automatic bulk_until_x(input int target);
      int w;
      int n = 0;
      mv = 1'b1;
      while (m_x != target && n < 3000) begin
         model_mv(w);
         tick();
         n++;
      end
      mv = 1'b0;
      check("reach_x", 32'(obj_x), target);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_x"},     32'(obj_x), 1920);
      check({tag, "_speed"}, 32'(speed), 4);
      check({tag, "_ts"},    32'(time_step), 0);
      check({tag, "_valid"}, 32'(obj_valid), 0);
      check({tag, "_state"}, 32'(state), 0);
      check({tag, "_wrap"},  32'(wrap), 0);
   endtask

   initial begin
      int xb;
      rst = 1'b1; mv = 1'b0; run = 1'b0; collide = 1'b0;
      model_clear();
      tick(); tick();
      check_idle("reset");
      rst = 1'b0;
      tick();

      run = 1'b1;
      tick();
      check("run_state", 32'(state), 1);
      check("run_valid", 32'(obj_valid), 1);

      for (int k = 0; k < 3; k++) begin
         single_mv("step");
         repeat (9) tick();
         check("step_hold", 32'(obj_x), m_x);
      end
      check("step_1908", 32'(obj_x), 1908);
      single_mv("b2b");
      single_mv("b2b");
      check("b2b_1900", 32'(obj_x), 1900);

      bulk_until_x(1000);
      collide = 1'b1; mv = 1'b1;
      tick();
      collide = 1'b0;
      check("hit_state", 32'(state), 2);
      check("hit_x", 32'(obj_x), 1000);
      check("hit_wrap", 32'(wrap), 0);
      collide = 1'b1;
      repeat (3) tick();
      mv = 1'b0; collide = 1'b0;
      check("hit_hold_x", 32'(obj_x), 1000);
      check("hit_hold_state", 32'(state), 2);
      run = 1'b0;
      tick();
      check_idle("hit_exit");
      model_clear();

      run = 1'b1;
      tick();
      bulk_until_x(4);
      single_mv("wrap_zero");
      check("wrap_zero_exact", 32'(obj_x), 0);
      single_mv("wrap_edge");
      check("wrap_edge_pulse", 32'(wrap), 1);
      tick();
      check("wrap_one_cycle", 32'(wrap), 0);

      bulk_mv(999 - m_tick);
      check("ramp_pre_speed", 32'(speed), 4);
      xb = m_x;
      single_mv("ramp1000");
      if (xb >= 4) check("ramp_old_step", 32'(obj_x), xb - 4);
      check("ramp_speed", 32'(speed), 5);
      check("ramp_ts", 32'(time_step), 1);

      bulk_mv(28000 - m_total);
      check("sat_speed", 32'(speed), 32);
      check("sat_ts", 32'(time_step), 28);
      check("sat_x", 32'(obj_x), m_x);
      single_mv("sat_step");

      run = 1'b0; mv = 1'b1;
      tick();
      mv = 1'b0;
      check_idle("drop");
      model_clear();

      run = 1'b1;
      tick();
      bulk_until_x(700);
      check("mid_state", 32'(state), 1);
      mv = 1'b1;
      #2 rst = 1'b1;
      #1;
      check_idle("async_rst");
      mv = 1'b0; run = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      repeat (5) begin
         mv = 1'b1;
         tick();
         mv = 1'b0;
         tick();
      end
      check_idle("idle_mv");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
